// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one registered adder across NUM_REQ requesters.
// Optional ADDER_ARB_STATS_EN adds per-requester grant counters and a busy counter.
module adder_rr_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 1,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_valid,
  input  logic [WIDTH:0]           add_sum,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH:0]           rsp_sum,
  output logic [ID_W-1:0]          rsp_id
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]    grant_cnt,
  output logic [31:0]              busy_cycles
`endif
);

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_any;
  logic [LATENCY-1:0] tag_vld;
  logic [ID_W-1:0]    tag_id [LATENCY];

  // Priority search starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'(idx);
      end
    end
    if (rst || !en) begin
      gnt_any = 1'b0;
      gnt_id  = '0;
    end
  end

  always_comb begin
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    if (gnt_any) begin
      req_ready[gnt_id] = 1'b1;
      add_a = req_a[int'(gnt_id)*WIDTH +: WIDTH];
      add_b = req_b[int'(gnt_id)*WIDTH +: WIDTH];
    end
    add_valid = |(req_valid & req_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (add_valid) begin
      if (gnt_id == ID_W'(NUM_REQ - 1))
        rr_ptr <= '0;
      else
        rr_ptr <= gnt_id + 1'b1;
    end
  end

  // Tag pipeline tracks which requester owns each in-flight sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
    end else begin
      tag_vld[0] <= add_valid;
      for (int k = 1; k < LATENCY; k++)
        tag_vld[k] <= tag_vld[k-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_id[0] <= gnt_id;
    for (int k = 1; k < LATENCY; k++)
      tag_id[k] <= tag_id[k-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
    end else begin
      rsp_valid <= '0;
      if (tag_vld[LATENCY-1]) begin
        rsp_valid <= NUM_REQ'(1) << tag_id[LATENCY-1];
        rsp_sum   <= add_sum;
        rsp_id    <= tag_id[LATENCY-1];
      end
    end
  end

`ifdef ADDER_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt   <= '0;
      busy_cycles <= '0;
    end else begin
      if (add_valid)
        busy_cycles <= busy_cycles + 32'd1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i] &&
            grant_cnt[i*16 +: 16] != 16'hFFFF)
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter with a behavioural adder and
// a response scoreboard checking id, sum and arrival cycle.
module tb_adder_rr_arbiter;
  localparam int W   = 32;
  localparam int N   = 4;
  localparam int LAT = 2;
  localparam int IW  = 2;

  typedef struct {
    int         id;
    logic [W:0] sum;
    int         due;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_valid;
  logic [W:0]     add_sum;
  logic [N-1:0]   rsp_valid;
  logic [W:0]     rsp_sum;
  logic [IW-1:0]  rsp_id;
`ifdef ADDER_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
  logic [31:0]     busy_cycles;
`endif

  logic [W-1:0] a [N];
  logic [W-1:0] b [N];
  logic [W:0]   s [LAT];
  exp_t         q [$];
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;

  adder_rr_arbiter #(
    .WIDTH(W), .NUM_REQ(N), .LATENCY(LAT), .ID_W(IW)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_valid(add_valid),
    .add_sum(add_sum),
    .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_id(rsp_id)
`ifdef ADDER_ARB_STATS_EN
    , .grant_cnt(grant_cnt), .busy_cycles(busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural registered adder, LAT stages deep.
  always @(posedge clk) begin
    s[0] <= {1'b0, add_a} + {1'b0, add_b};
    for (int k = 1; k < LAT; k++)
      s[k] <= s[k-1];
  end
  assign add_sum = s[LAT-1];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a[i];
      req_b[i*W +: W] = b[i];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop on every response, flag overdue or unexpected ones.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid !== '0) begin
      if (q.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
      end else begin
        e = q.pop_front();
        chk("rsp_cycle", 64'(cyc), 64'(e.due));
        chk("rsp_valid", 64'(rsp_valid), 64'(1) << e.id);
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
        chk("rsp_sum", 64'(rsp_sum), 64'(e.sum));
      end
    end else if (q.size() > 0 && q[0].due < cyc) begin
      e = q.pop_front();
      chk("rsp_missing", 64'(rsp_valid), 64'(1) << e.id);
    end
  end

  // Called at a negedge; drives req_valid, checks the grant, advances.
  task automatic step(input logic [N-1:0] v, input int g,
                      input bit push = 1'b1);
    req_valid = v;
    #1;
    if (g < 0) begin
      chk("ready_none", 64'(req_ready), 64'(0));
      chk("add_valid_none", 64'(add_valid), 64'(0));
      chk("add_a_none", 64'(add_a), 64'(0));
    end else begin
      chk("ready", 64'(req_ready), 64'(1) << g);
      chk("add_valid", 64'(add_valid), 64'(1));
      chk("add_a", 64'(add_a), 64'(a[g]));
      chk("add_b", 64'(add_b), 64'(b[g]));
      if (push)
        q.push_back('{g, {1'b0, a[g]} + {1'b0, b[g]}, cyc + LAT + 1});
    end
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    repeat (n) step('0, -1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b1;
    req_valid = '1;
    for (int i = 0; i < N; i++) begin
      a[i] = '0;
      b[i] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_add_valid", 64'(add_valid), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_sum", 64'(rsp_sum), 64'(0));
    chk("rst_rsp_id", 64'(rsp_id), 64'(0));
    req_valid = '0;
    rst = 1'b0;
    @(negedge clk);

    // Single request
    a[0] = 32'd100;
    b[0] = 32'd55;
    step(4'b0001, 0);
    drain(LAT + 2);

    // Four requesters back to back from a fresh pointer
    do_reset();
    for (int i = 0; i < N; i++) begin
      a[i] = 32'(i);
      b[i] = 32'd10;
    end
    for (int r = 0; r < 8; r++)
      step(4'b1111, r % N);
    drain(LAT + 2);

    // Carry into bit WIDTH
    a[1] = 32'hFFFF_FFFF;
    b[1] = 32'd1;
    step(4'b0010, 1);
    drain(LAT + 2);

    // Pointer wraps after requester 3
    a[0] = 32'd7;
    b[3] = 32'd20;
    step(4'b1000, 3);
    step(4'b1001, 0);
    step(4'b1001, 3);
    drain(LAT + 2);

    // Enable drop: in-flight ops finish, pointer holds at 3
    step(4'b0110, 1);
    step(4'b0110, 2);
    en = 1'b0;
    repeat (4) step(4'b0110, -1);
    en = 1'b1;
    step(4'b1111, 3);
    drain(LAT + 2);

    // Reset one clock after a handshake drops the op
    step(4'b0001, 0, 1'b0);
    rst = 1'b1;
    req_valid = 4'b0001;
    #1;
    chk("midrst_ready", 64'(req_ready), 64'(0));
    chk("midrst_add_valid", 64'(add_valid), 64'(0));
    @(negedge clk);
    #1;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("midrst_rsp_sum", 64'(rsp_sum), 64'(0));
    chk("midrst_rsp_id", 64'(rsp_id), 64'(0));
    rst = 1'b0;
    req_valid = '0;
    @(negedge clk);
    drain(LAT + 3);
    a[0] = 32'd1;
    b[0] = 32'd2;
    step(4'b0011, 0);
    drain(LAT + 3);

    chk("queue_empty", 64'(q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
- Round-robin arbiter that shares one registered adder (a, b, valid in; sum out after LATENCY clocks) among NUM_REQ requesters.
- Accepts operand pairs through per-requester valid/ready handshakes and drives the adder.
- Tracks the granted requester through a tag pipeline matched to the adder latency.
- Returns each sum to its originator with a one-hot response strobe. Sits between the requesters and the adder instance.

Parameters:
- WIDTH, 32, operand width; sums are WIDTH+1 bits.
- NUM_REQ, 4, number of requesters (2..16).
- LATENCY, 1, adder clocks from sampled valid to sum (1..4).
- ID_W, $clog2(NUM_REQ), requester index width.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  reset, synchronous and active-high.
- en  in  1  arbitration enable; low blocks new grants while in-flight results drain.
- req_valid  in  NUM_REQ  requester i has an operand pair.
- req_ready  out  NUM_REQ  one-hot grant; transfer occurs when req_valid[i] and req_ready[i] are both high at posedge.
- req_a  in  NUM_REQ*WIDTH  packed operand A, slice i belongs to requester i.
- req_b  in  NUM_REQ*WIDTH  packed operand B.
- add_a  out  WIDTH  adder operand A.
- add_b  out  WIDTH  adder operand B.
- add_valid  out  1  adder valid.
- add_sum  in  WIDTH+1  adder result.
- rsp_valid  out  NUM_REQ  one-hot response strobe, 1 cycle.
- rsp_sum  out  WIDTH+1  response data.
- rsp_id  out  ID_W  index of the responding requester.

Behaviour:
- Reset values: rr_ptr=0; tag pipeline valid bits=0; rsp_valid=0, rsp_sum=0, rsp_id=0; stats counters=0.
- During rst=1: req_ready=0 and add_valid=0.
- Grant (combinational):
  - Search starts at rr_ptr and wraps modulo NUM_REQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1. At most one bit is set.
  - No grant if en=0, rst=1 or no request.
- Adder drive (combinational from grant):
  - add_a/add_b = granted slices; add_valid = |(req_valid & req_ready).
  - With no grant: add_valid=0 and add_a/add_b=0.
- Pointer update: on a handshake with index g, rr_ptr <= (g+1) mod NUM_REQ. Otherwise rr_ptr holds.
- Fairness: a continuously asserted req_valid is granted within NUM_REQ grants.
- Tag pipeline:
  - LATENCY-deep shift register of {vld, id}. Stage 0 captures {add_valid, g} every posedge.
  - When the last stage is valid, add_sum is registered into rsp_sum, rsp_id <= id, and rsp_valid <= one-hot(id).
  - Total request-to-response latency is LATENCY+1 clocks (handshake edge to rsp_valid high).
- Responses cannot be back-pressured; requesters must sink them. Throughput is one op per clock.
- Combinational and sequential paths are separate; no request-to-ready timing loop beyond the priority search.
- en deasserted mid-stream: in-flight ops still complete and respond; rr_ptr holds.
- Reset mid-operation: the tag pipeline is cleared; in-flight results are dropped and produce no rsp_valid.
- Boundary conditions:
  - NUM_REQ=1 degenerates to a pass-through; rr_ptr stays 0.
  - The pointer wraps from NUM_REQ-1 to 0.
  - Sum carry occupies bit WIDTH, e.g. all-ones + 1 = {1, 0...}.

Optional Feature:
- Macro: ADDER_ARB_STATS_EN.
- When defined:
  - Adds output grant_cnt (NUM_REQ*16 bits): one saturating 16-bit counter per requester, incremented on each handshake and held at 0xFFFF.
  - Adds output busy_cycles (32 bits), counting cycles with add_valid=1, wrapping.
  - All counters clear on rst.
- When undefined: the ports and logic are absent and the behaviour is otherwise identical.

Test Plan:
- Reset, then single request: req_valid=0001, a0=100, b0=55 -> req_ready=0001 same cycle; rsp_valid=0001, rsp_sum=155, rsp_id=0 exactly LATENCY+1 clocks later.
- All four requesting continuously for 8 clocks, a_i=i, b_i=10 -> grant order 0,1,2,3,0,1,2,3; responses 10,11,12,13 repeating, one per clock, no gaps.
- Carry: a=0xFFFFFFFF, b=1 -> rsp_sum=0x1_0000_0000 (33 bits), no truncation.
- Sparse pointer wrap: only requester 3 grants, then requesters 0 and 3 request together -> requester 0 is granted first (rr_ptr=0 after the wrap).
- en drop: issue 2 ops, lower en the next cycle while req_valid is held -> both responses arrive, req_ready stays 0, rr_ptr is unchanged when en is raised again.
- rst asserted one clock after a handshake with LATENCY=2 -> no rsp_valid for that op, all outputs read reset values, and the next request after rst works normally.
